// File: rtl/controlador_rodadas_pkg.sv
// rtl/controlador_rodadas_pkg.sv - state codes and shared constants for the round controller
package controlador_rodadas_pkg;

  // Default number of cycles a player may take before the round is lost by timeout
  localparam int TIMEOUT_CICLOS_PADRAO = 5000;

  // State codes are visible on db_estado, so their values are fixed
  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicia_rodada  = 4'h2,
    espera_jogada  = 4'h3,
    registra       = 4'h4,
    compara        = 4'h5,
    proxima_jogada = 4'h6,
    proxima_rodada = 4'h7,
    fim_ganhou     = 4'hA,
    fim_timeout    = 4'hD,
    fim_perdeu     = 4'hE
  } estado_t;

  // Counter width for a given cycle budget; never narrower than one bit
  function automatic int largura_contador(input int ciclos);
    return (ciclos > 1) ? $clog2(ciclos) : 1;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// rtl/contador_timeout.sv - saturating cycle counter that flags the last allowed wait cycle
module contador_timeout
  import controlador_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int            W      = largura_contador(TIMEOUT_CICLOS);
  localparam logic [W-1:0]  ULTIMO = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] contagem;

  // Clear has priority; counting stops at the terminal value so the count never wraps
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      contagem <= '0;
    end else if (conta && (contagem != ULTIMO)) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/controlador_rodadas.sv
// rtl/controlador_rodadas.sv - Moore FSM sequencing rounds, plays and game end of the memory game
module controlador_rodadas
  import controlador_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       jogada_correta,
  input  logic       fim_jogada,
  input  logic       fim_rodadas,
  output logic       zera_E,
  output logic       conta_E,
  output logic       zera_R,
  output logic       conta_R,
  output logic       registra_R,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t proximo;

  logic tempo_esgotado;
  logic zera_timeout;
  logic conta_timeout;

  // The timeout counter only runs while waiting for a press and restarts on every entry
  assign zera_timeout  = (estado != espera_jogada);
  assign conta_timeout = (estado == espera_jogada);

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timeout),
    .conta (conta_timeout),
    .fim   (tempo_esgotado)
  );

  // State register with synchronous reset to inicial
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= inicial;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic; a press on the last allowed cycle beats the timeout
  always_comb begin
    proximo = inicial;
    case (estado)
      inicial:        proximo = jogar ? preparacao : inicial;
      preparacao:     proximo = inicia_rodada;
      inicia_rodada:  proximo = espera_jogada;
      espera_jogada: begin
        if (tem_jogada) begin
          proximo = registra;
        end else if (tempo_esgotado) begin
          proximo = fim_timeout;
        end else begin
          proximo = espera_jogada;
        end
      end
      registra:       proximo = compara;
      compara: begin
        if (!jogada_correta) begin
          proximo = fim_perdeu;
        end else if (!fim_jogada) begin
          proximo = proxima_jogada;
        end else if (fim_rodadas) begin
          proximo = fim_ganhou;
        end else begin
          proximo = proxima_rodada;
        end
      end
      proxima_jogada: proximo = espera_jogada;
      proxima_rodada: proximo = inicia_rodada;
      fim_ganhou:     proximo = jogar ? preparacao : fim_ganhou;
      fim_timeout:    proximo = jogar ? preparacao : fim_timeout;
      fim_perdeu:     proximo = jogar ? preparacao : fim_perdeu;
      default:        proximo = inicial;
    endcase
  end

  // Output decode from the current state only
  always_comb begin
    zera_E     = 1'b0;
    conta_E    = 1'b0;
    zera_R     = 1'b0;
    conta_R    = 1'b0;
    registra_R = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    case (estado)
      preparacao: begin
        zera_E = 1'b1;
        zera_R = 1'b1;
      end
      inicia_rodada:  zera_E     = 1'b1;
      registra:       registra_R = 1'b1;
      proxima_jogada: conta_E    = 1'b1;
      proxima_rodada: conta_R    = 1'b1;
      fim_ganhou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      fim_perdeu: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      fim_timeout: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controlador_rodadas.sv
// tb/tb_controlador_rodadas.sv - randomized game-level bench for controlador_rodadas
module tb_controlador_rodadas;
  import controlador_rodadas_pkg::*;

  localparam int T = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic       tem_jogada;
  logic       jogada_correta;
  logic       fim_jogada;
  logic       fim_rodadas;
  logic       zera_E, conta_E, zera_R, conta_R, registra_R;
  logic       pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  int checks   = 0;
  int failures = 0;

  logic [3:0] mod_e = '0;
  logic [3:0] mod_r = '0;
  int n_conta_e = 0;
  int n_conta_r = 0;
  int n_zera_e  = 0;
  int n_zera_r  = 0;

  always #5 clock = ~clock;

  controlador_rodadas #(.TIMEOUT_CICLOS(T)) dut (
    .clock          (clock),
    .reset          (reset),
    .jogar          (jogar),
    .tem_jogada     (tem_jogada),
    .jogada_correta (jogada_correta),
    .fim_jogada     (fim_jogada),
    .fim_rodadas    (fim_rodadas),
    .zera_E         (zera_E),
    .conta_E        (conta_E),
    .zera_R         (zera_R),
    .conta_R        (conta_R),
    .registra_R     (registra_R),
    .pronto         (pronto),
    .ganhou         (ganhou),
    .perdeu         (perdeu),
    .db_timeout     (db_timeout),
    .db_estado      (db_estado)
  );

  // Datapath model: play and round counters driven by the controller strobes
  always @(negedge clock) begin
    if (zera_E) mod_e = '0;
    else if (conta_E) mod_e = mod_e + 4'd1;
    if (zera_R) mod_r = '0;
    else if (conta_R) mod_r = mod_r + 4'd1;
    if (conta_E) n_conta_e++;
    if (conta_R) n_conta_r++;
    if (zera_E) n_zera_e++;
    if (zera_R) n_zera_r++;
  end

  assign fim_jogada  = (mod_e == mod_r);
  assign fim_rodadas = (mod_r == 4'd15);

  task automatic checa(input string tag, input int obs, input int esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic espera_estado(input logic [3:0] alvo, input int limite, input string tag,
                               output bit ok);
    int n = 0;
    while (db_estado !== alvo && n < limite) begin
      @(negedge clock);
      n++;
    end
    ok = (db_estado === alvo);
    checa(tag, int'(db_estado), int'(alvo));
  endtask

  task automatic recupera();
    jogar = 1'b0;
    tem_jogada = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // End-of-game checks: state, flags, strobe totals, and that the final state holds
  task automatic confere_fim(input logic [3:0] est, input logic [3:0] flags,
                             input int esp_e, input int esp_r, input int base_e, input int base_r);
    bit ok;
    jogar = 1'b0;
    espera_estado(est, 6, "estado_final", ok);
    if (!ok) begin
      recupera();
      return;
    end
    checa("flags_final", int'({pronto, ganhou, perdeu, db_timeout}), int'(flags));
    checa("conta_E_total", n_conta_e - base_e, esp_e);
    checa("conta_R_total", n_conta_r - base_r, esp_r);
    repeat (8) @(negedge clock);
    checa("final_mantem", int'(db_estado), int'(est));
    checa("conta_E_parado", n_conta_e - base_e, esp_e);
    checa("conta_R_parado", n_conta_r - base_r, esp_r);
  endtask

  // modo: 0 win, 1 wrong button at (r_alvo,p_alvo), 2 timeout there, 3 reset in compara there
  task automatic partida(input int modo, input int r_alvo, input int p_alvo, input bit iniciar);
    int  base_e, base_r, esp_e, esp_r, gap, n;
    bit  ok, alvo;
    base_e = n_conta_e;
    base_r = n_conta_r;
    esp_r  = (modo == 0) ? 15 : r_alvo;
    esp_e  = (modo == 0) ? 120 : (r_alvo * (r_alvo - 1)) / 2 + p_alvo;
    if (iniciar) begin
      jogar = 1'b1;
      @(negedge clock);
      jogar = 1'b0;
      checa("inicio_estado", int'(db_estado), int'(preparacao));
      checa("inicio_flags", int'({pronto, ganhou, perdeu, db_timeout}), 0);
    end
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p <= r; p++) begin
        espera_estado(espera_jogada, 12, "chega_espera", ok);
        if (!ok) begin
          recupera();
          return;
        end
        alvo = (r == r_alvo) && (p == p_alvo) && (modo != 0);
        if (alvo && modo == 2) begin
          jogar = 1'b0;
          n = 0;
          while (db_estado === espera_jogada && n < 100) begin
            n++;
            @(negedge clock);
          end
          checa("ciclos_ate_timeout", n, T);
          confere_fim(fim_timeout, 4'b1011, esp_e, esp_r, base_e, base_r);
          return;
        end
        gap = ($urandom_range(5) == 0) ? T - 1 : $urandom_range(T - 2);
        jogar = 1'($urandom_range(1));
        repeat (gap) @(negedge clock);
        tem_jogada = 1'b1;
        jogada_correta = !(alvo && modo == 1);
        @(negedge clock);
        tem_jogada = 1'b0;
        jogar = 1'b0;
        checa(gap == T - 1 ? "registra_ultimo_ciclo" : "registra", int'(db_estado), int'(registra));
        checa("registra_R", int'(registra_R), 1);
        if (alvo && modo == 3) begin
          @(negedge clock);
          checa("em_compara", int'(db_estado), int'(compara));
          reset = 1'b1;
          @(negedge clock);
          checa("reset_saidas", int'({zera_E, conta_E, zera_R, conta_R, registra_R,
                                      pronto, ganhou, perdeu, db_timeout, db_estado}), 0);
          reset = 1'b0;
          return;
        end
        if (alvo && modo == 1) begin
          confere_fim(fim_perdeu, 4'b1010, esp_e, esp_r, base_e, base_r);
          return;
        end
      end
    end
    confere_fim(fim_ganhou, 4'b1100, esp_e, esp_r, base_e, base_r);
  endtask

  initial begin
    int base_zr, base_ze, r, modo;
    reset = 1'b1;
    jogar = 1'b0;
    tem_jogada = 1'b0;
    jogada_correta = 1'b1;
    repeat (2) @(negedge clock);
    checa("reset_estado", int'(db_estado), 0);
    checa("reset_saidas_ini", int'({zera_E, conta_E, zera_R, conta_R, registra_R,
                                    pronto, ganhou, perdeu, db_timeout}), 0);
    reset = 1'b0;
    @(negedge clock);
    checa("inicial_mantem", int'(db_estado), int'(inicial));

    // Held jogar walks 0->1->2->3 and does not restart the game
    base_zr = n_zera_r;
    base_ze = n_zera_e;
    jogar = 1'b1;
    @(negedge clock); checa("seq_1", int'(db_estado), 1);
    @(negedge clock); checa("seq_2", int'(db_estado), 2);
    @(negedge clock); checa("seq_3", int'(db_estado), 3);
    @(negedge clock); checa("seq_3b", int'(db_estado), 3);
    @(negedge clock); checa("seq_3c", int'(db_estado), 3);
    jogar = 1'b0;
    checa("zera_R_ciclos", n_zera_r - base_zr, 1);
    checa("zera_E_ciclos", n_zera_e - base_ze, 2);

    partida(0, 0, 0, 1'b0);
    partida(1, 4, 2, 1'b1);
    partida(2, 0, 0, 1'b1);
    partida(3, 2, 1, 1'b1);
    partida(0, 0, 0, 1'b1);
    for (int g = 0; g < 6; g++) begin
      modo = $urandom_range(1, 3);
      r = $urandom_range(15);
      partida(modo, r, $urandom_range(r), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
